aes_key_sched_iter: RTL and testbench
=====================================

# aes_key_sched_iter

Iterative, parametrised AES key-schedule engine that expands one cipher key into the full round-key set and holds it for indexed readout. It is the successor to the per-round unrolled `expand_key_128` chain. It supports AES-128 and AES-256 from one RTL source, and computes one round key every two cycles through a single shared registered S-box. It feeds round-serial datapaths, which fetch round keys by index instead of receiving a 128-bit key bus per pipeline stage.

## Interface
Parameters:
- KEY_BITS, 128, cipher key width; legal values 128 or 256 (elaboration error otherwise)
- NR, derived, 10 for 128, 14 for 256; last round-key index

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin expansion of `key`; sampled only in IDLE
- key  in  KEY_BITS  cipher key, MSB = first key byte; sampled on accepted start
- busy  out  1  high while expansion in progress
- done  out  1  one-cycle pulse, set on the edge that writes rk[NR]
- rk_valid  out  1  high while stored set is complete and unchanged
- rk_idx  in  4  round-key index to read
- rk_data  out  128  registered read of rk[rk_idx]; zero if rk_idx > NR

## Operation
- FSM states:
  - IDLE: on start, latch key and go to SUB.
    - KEY_BITS=128: write rk0 = key, n = 1.
    - KEY_BITS=256: write rk0 = key[255:128], rk1 = key[127:0], n = 2.
  - SUB: drive S4 input with the last word w of prev1 = rk[n-1].
    - RotWord(w) = {w[23:0], w[31:24]} when (KEY_BITS=128) or (n even).
    - w unrotated when KEY_BITS=256 and n is odd.
  - MIX: t = S4 output, XORed with {rcon, 24'h0} when the rotate case applies.
    - base = rk[n-1] (128) or rk[n-2] (256).
    - Words: c0 = base0^t, c1 = base1^c0, c2 = base2^c1, c3 = base3^c2.
    - Write rk[n], shift prev2 <= prev1, prev1 <= new key.
    - If n == NR, go to IDLE with done; else n++ and go to SUB.
- Rcon index:
  - 128: rk[n] uses rcon[n-1] = 01,02,04,08,10,20,40,80,1b,36.
  - 256: even n uses rcon[n/2-1] = 01..40.
- prev1/prev2 working registers avoid read-port contention with the key store.
- start while busy: ignored.
- start in IDLE while rk_valid=1: rk_valid clears on that edge, and the set is recomputed.
- rk_valid sets together with done.
- The read port is live at all times; reads during expansion return partially updated contents with rk_valid=0.
- Reset, asynchronous: FSM to IDLE; n, prev1, prev2, the whole key store and rk_data to 0; busy=0, done=0, rk_valid=0. Reset mid-expansion aborts and discards the set.

## Timing
- Edge E0 samples start. busy is high from the cycle after E0 through the cycle containing the final MIX edge.
- 128: rk[n] is written at E(2n); rk10 and done at E20. The done pulse is visible for the cycle after E20.
- 256: rk0/rk1 are written at E0; rk[n] is written at E(2n-2); rk14 and done at E26.
- Back-to-back start is accepted the first IDLE cycle after done, giving throughput of one key set per 21 or 27 cycles.
- rk_data latency is 1 cycle: rk_idx sampled at edge k produces data valid after edge k.
- The S4 sub-module has 1-cycle registered latency; this is the sole reason for SUB/MIX pairing.

## Structure
- Shared package `aes_pkg` holds:
  - the rcon byte table (10 entries)
  - the FSM state enum {IDLE, SUB, MIX}
  - an NR-from-KEY_BITS function
  - the round-key width constant (128)
- Sub-module: the existing `S4` 4-byte registered S-box, one instance.
- Key store: a flop array of NR+1 entries by 128 bits, with a single write port and a single registered read port.

## Test plan
- AES-128 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> rk1 = a0fafe1788542cb123a339392a6c7605, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done exactly 20 cycles after start.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk2 = 9ba354118e6925afa51a8b5f2067fcde, rk14 = fe4890d1e6188d0b046df344706c631e, done at 26 cycles.
- start pulsed every cycle during busy -> single done; rk set identical to the single-start run.
- Reset asserted at cycle 7 of expansion -> all outputs 0 immediately; a subsequent clean start yields correct vectors.
- Restart in IDLE with a new key after completion -> rk_valid drops on the start edge and rises with the new done; rk_idx=15 reads 0.
- Read sweep rk_idx 0..NR after done -> each rk_data matches the model one cycle after index change.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   RK_BITS : round-key width
//   RCON    : round-constant bytes, rcon[0..9]
//   state_t : expansion FSM states
//   nr_of() : last round-key index for a given cipher key width
package aes_pkg;

    localparam int RK_BITS = 128;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2
    } state_t;

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_key_sched_iter_s4.sv
// S4: four parallel AES S-boxes with one registered stage.
//   clk, rst : clock, async active-high reset (clears output)
//   din      : 32-bit word to substitute
//   dout     : SubWord(din), valid one cycle after din
// The S-box is the GF(2^8) inverse (x^254) followed by the affine map,
// so no lookup table has to be maintained by hand.
module S4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                dout[8*b +: 8] <= sbox(din[8*b +: 8]);
            end
        end
    end

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128/256 key-schedule engine with indexed round-key readout.
//   clk, rst  : clock, async active-high reset
//   start     : begin expansion of key (accepted only in IDLE)
//   key       : cipher key, MSB is the first key byte
//   busy      : expansion in progress
//   done      : one-cycle pulse after rk[NR] is written
//   rk_valid  : stored round-key set is complete and unchanged
//   rk_idx    : round-key index to read
//   rk_data   : registered rk[rk_idx], zero when rk_idx > NR
// One round key is produced per SUB/MIX pair: SUB presents the last word of
// the previous round key to the registered S4, MIX folds the result into the
// base round key and writes the new one.
module aes_key_sched_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                done,
    output logic                rk_valid,
    input  logic [3:0]          rk_idx,
    output logic [RK_BITS-1:0]  rk_data
);

    localparam int         NR  = nr_of(KEY_BITS);
    localparam logic [3:0] NR4 = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_sched_iter: KEY_BITS must be 128 or 256");
        end
    endgenerate

    state_t             state, state_nxt;
    logic [3:0]         n;
    logic [RK_BITS-1:0] prev1, prev2;
    logic [RK_BITS-1:0] store [0:NR];

    logic               load, mix_we, last;
    logic [255:0]       key_ext;
    logic [RK_BITS-1:0] first_rk;
    logic               rot;
    logic [3:0]         rc_idx;
    logic [7:0]         rc;
    logic [31:0]        s4_in, s4_out, t;
    logic [RK_BITS-1:0] base, new_rk;
    logic [31:0]        c0, c1, c2, c3;

    // Zero-extend so both key widths can be sliced with constant ranges.
    assign key_ext  = 256'(key);
    assign first_rk = (KEY_BITS == 256) ? key_ext[255:128] : key_ext[127:0];
    assign last     = (n == NR4);
    assign busy     = (state != IDLE);

    // AES-256 alternates: even n gets RotWord+Rcon, odd n only SubWord.
    assign rot    = (KEY_BITS == 128) || !n[0];
    assign rc_idx = (KEY_BITS == 128) ? (n - 4'd1) : ({1'b0, n[3:1]} - 4'd1);
    assign rc     = (rc_idx < 4'd10) ? RCON[rc_idx] : 8'h00;

    assign s4_in = rot ? {prev1[23:0], prev1[31:24]} : prev1[31:0];

    S4 u_s4 (
        .clk  (clk),
        .rst  (rst),
        .din  (s4_in),
        .dout (s4_out)
    );

    assign t      = s4_out ^ (rot ? {rc, 24'h0} : 32'h0);
    assign base   = (KEY_BITS == 256) ? prev2 : prev1;
    assign c0     = base[127:96] ^ t;
    assign c1     = base[95:64]  ^ c0;
    assign c2     = base[63:32]  ^ c1;
    assign c3     = base[31:0]   ^ c2;
    assign new_rk = {c0, c1, c2, c3};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        mix_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SUB;
                end
            end
            SUB: state_nxt = MIX;
            MIX: begin
                mix_we    = 1'b1;
                state_nxt = last ? IDLE : SUB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers: prev1 = rk[n-1], prev2 = rk[n-2], so the key store
    // never needs a second read port during expansion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= '0;
            prev1    <= '0;
            prev2    <= '0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
        end else begin
            done <= mix_we && last;
            if (load) begin
                rk_valid <= 1'b0;
                if (KEY_BITS == 256) begin
                    prev2 <= key_ext[255:128];
                    prev1 <= key_ext[127:0];
                    n     <= 4'd2;
                end else begin
                    prev2 <= '0;
                    prev1 <= key_ext[127:0];
                    n     <= 4'd1;
                end
            end else if (mix_we) begin
                prev2 <= prev1;
                prev1 <= new_rk;
                if (last) rk_valid <= 1'b1;
                else      n        <= n + 4'd1;
            end
        end
    end

    // Key store. AES-256 loads two round keys straight from the cipher key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) store[i] <= '0;
        end else if (load) begin
            store[0] <= first_rk;
            if (KEY_BITS == 256) store[1] <= key_ext[127:0];
        end else if (mix_we) begin
            store[n] <= new_rk;
        end
    end

    // Registered read port, live at all times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                rk_data <= '0;
        else if (rk_idx <= NR4) rk_data <= store[rk_idx];
        else                    rk_data <= '0;
    end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Bench for aes_key_sched_iter: one AES-128 and one AES-256 instance,
// FIPS-197 vectors plus an independent word-wise key-expansion model.
module tb_aes_key_sched_iter;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic [127:0] key_a;
    logic [255:0] key_b;
    logic [3:0]   rk_idx;
    logic         busy_a, done_a, valid_a;
    logic         busy_b, done_b, valid_b;
    logic [127:0] data_a, data_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_key_sched_iter #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .key(key_a),
        .busy(busy_a), .done(done_a), .rk_valid(valid_a),
        .rk_idx(rk_idx), .rk_data(data_a)
    );

    aes_key_sched_iter #(.KEY_BITS(256)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .key(key_b),
        .busy(busy_b), .done(done_b), .rk_valid(valid_b),
        .rk_idx(rk_idx), .rk_data(data_b)
    );

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Standard FIPS-197 word expansion; k is right-aligned for 128-bit keys.
    function automatic logic [127:0] model_rk(input logic [255:0] k, input int kb, input int idx);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = kb / 32;
        nr = (kb == 256) ? 14 : 10;
        if (idx > nr) return '0;
        for (int j = 0; j < nk; j++) w[j] = k[(kb - 1 - 32*j) -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [127:0] data_of(input int w);  return (w == 0) ? data_a : data_b; endfunction
    function automatic logic         busy_of(input int w);  return (w == 0) ? busy_a : busy_b; endfunction
    function automatic logic         done_of(input int w);  return (w == 0) ? done_a : done_b; endfunction
    function automatic logic         valid_of(input int w); return (w == 0) ? valid_a : valid_b; endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int           which;
        logic [127:0] exp;
    } exp_t;
    exp_t sbq[$];

    // Index driven at negedge, sampled by the DUT on the next posedge,
    // expected on rk_data just after that edge.
    task automatic rd(input int which, input int idx, input logic [127:0] exp,
                      input string tag, input bit chk_hold, input logic [127:0] prev);
        exp_t e;
        @(negedge clk);
        rk_idx  = 4'(idx);
        e.which = which;
        e.exp   = exp;
        sbq.push_back(e);
        if (chk_hold) begin
            #1;
            check({tag, "_hold"}, data_of(which), prev);
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check($sformatf("%s_rk%0d", tag, idx), data_of(e.which), e.exp);
    endtask

    task automatic sweep(input int which, input logic [255:0] k, input string tag);
        int           nr;
        int           kb;
        logic [127:0] e;
        logic [127:0] prev;
        nr   = (which == 0) ? 10 : 14;
        kb   = (which == 0) ? 128 : 256;
        prev = model_rk(k, kb, 0);
        rd(which, 0, prev, tag, 1'b0, '0);
        for (int i = 1; i <= nr; i++) begin
            e = model_rk(k, kb, i);
            rd(which, i, e, tag, 1'b1, prev);
            prev = e;
        end
        rd(which, 15, '0, tag, 1'b0, '0);
    endtask

    // Returns just after E0 (the edge that samples start).
    task automatic do_start(input int which, input logic [255:0] k);
        @(negedge clk);
        if (which == 0) begin start_a = 1'b1; key_a = k[127:0]; end
        else            begin start_b = 1'b1; key_b = k;        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int which, input int exp_lat, input string tag);
        int lat;
        int vbad;
        lat  = 0;
        vbad = 0;
        while (done_of(which) !== 1'b1 && lat < 200) begin
            if (valid_of(which) !== 1'b0) vbad++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_valid_low_while_busy"}, 128'(vbad), 128'd0);
        check({tag, "_valid_at_done"}, 128'(valid_of(which)), 128'd1);
        check({tag, "_busy_after_done"}, 128'(busy_of(which)), 128'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 128'(done_of(which)), 128'd0);
    endtask

    typedef struct {
        int           which;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    initial begin
        vec_t         vecs [9];
        logic [255:0] kr;
        logic [7:0]   inv;
        logic [7:0]   xb;
        int           lat;
        int           ndone;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            xb = inv;
            sb[x] = xb ^ {xb[6:0], xb[7]} ^ {xb[5:0], xb[7:6]} ^ {xb[4:0], xb[7:5]}
                       ^ {xb[3:0], xb[7:4]} ^ 8'h63;
        end

        vecs[0] = '{0, 0,  K128};
        vecs[1] = '{0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{0, 15, 128'h0};
        vecs[4] = '{1, 0,  128'h603deb1015ca71be2b73aef0857d7781};
        vecs[5] = '{1, 1,  128'h1f352c073b6108d72d9810a30914dff4};
        vecs[6] = '{1, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[7] = '{1, 14, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[8] = '{1, 15, 128'h0};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        key_a = '0; key_b = '0; rk_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_a",  128'(busy_a),  128'd0);
        check("rst_done_a",  128'(done_a),  128'd0);
        check("rst_valid_a", 128'(valid_a), 128'd0);
        check("rst_data_a",  data_a,        128'd0);
        check("rst_busy_b",  128'(busy_b),  128'd0);
        check("rst_valid_b", 128'(valid_b), 128'd0);
        check("rst_data_b",  data_b,        128'd0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 expansions
        do_start(0, {128'h0, K128});
        check("a_busy_e0", 128'(busy_a), 128'd1);
        wait_done(0, 20, "a_fips");
        do_start(1, K256);
        check("b_busy_e0", 128'(busy_b), 128'd1);
        wait_done(1, 26, "b_fips");

        for (int i = 0; i < 9; i++)
            rd(vecs[i].which, vecs[i].idx, vecs[i].exp, $sformatf("vec%0d", i), 1'b0, '0);

        sweep(0, {128'h0, K128}, "a_sweep");
        sweep(1, K256, "b_sweep");

        // start held high for the whole expansion, key wiggling meanwhile
        kr = {128'h0, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start_a = 1'b1;
        key_a   = kr[127:0];
        @(posedge clk);
        #1;
        check("hold_busy_e0", 128'(busy_a), 128'd1);
        lat = 0;
        while (done_a !== 1'b1 && lat < 200) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            lat++;
        end
        start_a = 1'b0;
        check("hold_done_lat", 128'(lat), 128'd20);
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        check("hold_extra_done", 128'(ndone), 128'd0);
        check("hold_valid", 128'(valid_a), 128'd1);
        sweep(0, kr, "hold_sweep");

        // restart in IDLE with a new key while the old set is valid
        kr = {128'h0, $urandom, $urandom, $urandom, $urandom};
        check("restart_valid_before", 128'(valid_a), 128'd1);
        do_start(0, kr);
        check("restart_valid_drop", 128'(valid_a), 128'd0);
        wait_done(0, 20, "restart");
        rd(0, 15, '0, "restart_idx15", 1'b0, '0);
        sweep(0, kr, "restart_sweep");

        // reset in the middle of an AES-256 expansion
        kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        rk_idx = 4'd0;
        do_start(1, kr);
        repeat (6) @(posedge clk);
        check("mid_data_before_rst", data_b, model_rk(kr, 256, 0));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy_b",  128'(busy_b),  128'd0);
        check("mid_rst_done_b",  128'(done_b),  128'd0);
        check("mid_rst_valid_b", 128'(valid_b), 128'd0);
        check("mid_rst_data_b",  data_b,        128'd0);
        check("mid_rst_data_a",  data_a,        128'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(1, 0, '0, "mid_store_b_clear", 1'b0, '0);
        rd(0, 1, '0, "mid_store_a_clear", 1'b0, '0);
        do_start(1, K256);
        wait_done(1, 26, "after_rst");
        rd(1, 2,  128'h9ba354118e6925afa51a8b5f2067fcde, "after_rst_fips", 1'b0, '0);
        rd(1, 14, 128'hfe4890d1e6188d0b046df344706c631e, "after_rst_fips", 1'b0, '0);
        sweep(1, K256, "after_rst_sweep");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
